// File: rtl/uart_pci_master_if.sv
// Byte-stream and PCI control lines between the UART command bridge and its surroundings.
// The tri-stated ad/cbe_ buses stay as plain ports on the master itself.
`timescale 1ns/1ps
interface uart_pci_master_if;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic [7:0] tx_data;
  logic       tx_load;
  logic       tx_busy;
  logic       frame_;
  logic       irdy_;
  logic       devsel_;
  logic       trdy_;
  logic       stop_;
  logic       busy;

  modport master (
    input  rx_valid, rx_data, tx_busy, devsel_, trdy_, stop_,
    output tx_data, tx_load, frame_, irdy_, busy
  );

  modport slave (
    output rx_valid, rx_data, tx_busy, devsel_, trdy_, stop_,
    input  tx_data, tx_load, frame_, irdy_, busy
  );
endinterface

// File: rtl/uart_pci_master.sv
// UART-driven PCI master: collects a 9-byte command frame, runs one single-phase
// memory read/write on the bus and answers with a status byte (plus read data).
`timescale 1ns/1ps
module uart_pci_master #(
  parameter int DEVSEL_TIMEOUT = 5,
  parameter int TRDY_TIMEOUT   = 16,
  parameter int BYTE_TIMEOUT   = 65535
) (
  input  logic              clk,
  input  logic              rst_,
  uart_pci_master_if.master bus,
  inout  wire  [31:0]       ad,
  output wire  [3:0]        cbe_
);
  localparam int DW = $clog2(DEVSEL_TIMEOUT + 1);
  localparam int TW = $clog2(TRDY_TIMEOUT + 1);
  localparam int BW = $clog2(BYTE_TIMEOUT + 1);

  typedef enum logic [2:0] {COLLECT, ADDR, DATA, TURN, RESP} state_t;

  state_t        state;
  logic [3:0]    byte_cnt;
  logic [3:0]    cmd;
  logic [31:0]   addr, wdata, rdata;
  logic [31:0]   ad_q;
  logic [3:0]    cbe_q;
  logic          ad_oe, cbe_oe;
  logic          frame_q, irdy_q, tx_load_q, busy_q;
  logic [7:0]    tx_data_q, status;
  logic [2:0]    resp_idx, resp_last;
  logic [BW-1:0] idle_cnt;
  logic [DW-1:0] dev_cnt;
  logic [TW-1:0] trdy_cnt;
  logic          data_done;
  logic [7:0]    data_status;

  function automatic logic [7:0] resp_byte(input logic [2:0] idx, input logic [7:0] st,
                                           input logic [31:0] rd);
    case (idx)
      3'd1:    return rd[7:0];
      3'd2:    return rd[15:8];
      3'd3:    return rd[23:16];
      3'd4:    return rd[31:24];
      default: return st;
    endcase
  endfunction

  assign ad          = ad_oe  ? ad_q  : 32'bz;
  assign cbe_        = cbe_oe ? cbe_q : 4'bz;
  assign bus.frame_  = frame_q;
  assign bus.irdy_   = irdy_q;
  assign bus.tx_load = tx_load_q;
  assign bus.tx_data = tx_data_q;
  assign bus.busy    = busy_q;

  // Target response decode for the current DATA clock; completion outranks stop_.
  always_comb begin
    data_done   = 1'b1;
    data_status = 8'h00;
    if (!bus.devsel_ && !bus.trdy_) begin
      data_status = 8'h00;
    end else if (!bus.stop_ && bus.trdy_) begin
      data_status = 8'h03;
    end else if (bus.devsel_) begin
      if (dev_cnt == DW'(DEVSEL_TIMEOUT - 1)) data_status = 8'h01;
      else                                    data_done   = 1'b0;
    end else begin
      if (trdy_cnt == TW'(TRDY_TIMEOUT - 1)) data_status = 8'h04;
      else                                   data_done   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state     <= COLLECT;
      byte_cnt  <= '0;
      cmd       <= '0;
      addr      <= '0;
      wdata     <= '0;
      rdata     <= '0;
      ad_q      <= '0;
      cbe_q     <= '0;
      ad_oe     <= 1'b0;
      cbe_oe    <= 1'b0;
      frame_q   <= 1'b1;
      irdy_q    <= 1'b1;
      tx_load_q <= 1'b0;
      tx_data_q <= '0;
      busy_q    <= 1'b0;
      status    <= '0;
      resp_idx  <= '0;
      resp_last <= '0;
      idle_cnt  <= '0;
      dev_cnt   <= '0;
      trdy_cnt  <= '0;
    end else begin
      tx_load_q <= 1'b0;
      unique case (state)
        COLLECT: begin
          if (bus.rx_valid) begin
            idle_cnt <= '0;
            if (byte_cnt == 4'd8) begin
              byte_cnt <= '0;
              cmd      <= bus.rx_data[3:0];
              busy_q   <= 1'b1;
              if (bus.rx_data[3:1] == 3'b011) begin
                state   <= ADDR;
                frame_q <= 1'b0;
                ad_q    <= addr;
                cbe_q   <= bus.rx_data[3:0];
                ad_oe   <= 1'b1;
                cbe_oe  <= 1'b1;
              end else begin
                state     <= RESP;
                status    <= 8'h02;
                resp_idx  <= '0;
                resp_last <= '0;
              end
            end else begin
              byte_cnt <= byte_cnt + 4'd1;
              if (!byte_cnt[2]) addr[{byte_cnt[1:0], 3'b000} +: 8]  <= bus.rx_data;
              else              wdata[{byte_cnt[1:0], 3'b000} +: 8] <= bus.rx_data;
            end
          end else if (byte_cnt != 4'd0) begin
            // A stalled partial frame is dropped silently.
            if (idle_cnt == BW'(BYTE_TIMEOUT - 1)) begin
              byte_cnt <= '0;
              idle_cnt <= '0;
            end else begin
              idle_cnt <= idle_cnt + BW'(1);
            end
          end
        end
        ADDR: begin
          state    <= DATA;
          frame_q  <= 1'b1;
          irdy_q   <= 1'b0;
          cbe_q    <= 4'h0;
          ad_q     <= wdata;
          ad_oe    <= (cmd == 4'h7);
          dev_cnt  <= '0;
          trdy_cnt <= '0;
        end
        DATA: begin
          if (data_done) begin
            state  <= TURN;
            status <= data_status;
            irdy_q <= 1'b1;
            ad_oe  <= 1'b0;
            cbe_oe <= 1'b0;
            if (data_status == 8'h00 && cmd != 4'h7) rdata <= ad;
          end else if (bus.devsel_) begin
            if (dev_cnt != DW'(DEVSEL_TIMEOUT)) dev_cnt <= dev_cnt + DW'(1);
          end else begin
            if (trdy_cnt != TW'(TRDY_TIMEOUT)) trdy_cnt <= trdy_cnt + TW'(1);
          end
        end
        TURN: begin
          state     <= RESP;
          resp_idx  <= '0;
          resp_last <= (cmd == 4'h6 && status == 8'h00) ? 3'd4 : 3'd0;
        end
        RESP: begin
          // The clock after a load is always skipped so the transmitter can raise tx_busy.
          if (!tx_load_q && !bus.tx_busy) begin
            tx_load_q <= 1'b1;
            tx_data_q <= resp_byte(resp_idx, status, rdata);
            if (resp_idx == resp_last) begin
              state  <= COLLECT;
              busy_q <= 1'b0;
            end else begin
              resp_idx <= resp_idx + 3'd1;
            end
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_pci_master.sv
// Bench for uart_pci_master: table of command frames with a scripted PCI target,
// response bytes checked through a scoreboard, plus reset and byte-timeout sequences.
`timescale 1ns/1ps
module tb_uart_pci_master;
  localparam int BYTE_TO = 200;
  localparam int M_OK = 0, M_NODEV = 1, M_STOP = 2, M_NOTRDY = 3, M_BOTH = 4, M_NONE = 5;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [7:0]  cmd;
    int          mode;
    int          at;
    logic [31:0] rdata;
    int          exp_clks;
    logic [7:0]  exp_status;
    int          gap;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_;
  wire  [31:0] ad;
  wire  [3:0]  cbe_;
  logic        tgt_oe;
  logic [31:0] tgt_val;
  logic [7:0]  sb[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          busy_cnt = 0;
  vec_t        vecs[10];

  uart_pci_master_if bus();

  uart_pci_master #(.DEVSEL_TIMEOUT(5), .TRDY_TIMEOUT(16), .BYTE_TIMEOUT(BYTE_TO)) dut (
    .clk(clk), .rst_(rst_), .bus(bus), .ad(ad), .cbe_(cbe_)
  );

  for (genvar i = 0; i < 32; i++) begin : g_pu_ad
    pullup (ad[i]);
  end
  for (genvar i = 0; i < 4; i++) begin : g_pu_cbe
    pullup (cbe_[i]);
  end

  assign ad = tgt_oe ? tgt_val : 32'bz;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Transmitter model and response scoreboard.
  always @(negedge clk) begin
    if (bus.tx_load === 1'b1) begin
      check("load_while_tx_idle", {31'd0, bus.tx_busy}, 32'd0);
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_tx_load: got byte %h, required no load", bus.tx_data);
      end else begin
        check("tx_byte", {24'd0, bus.tx_data}, {24'd0, sb.pop_front()});
      end
      busy_cnt = 3;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
    end
    bus.tx_busy = (busy_cnt != 0);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_frame(input vec_t v);
    for (int i = 0; i < 4; i++) send_byte(v.addr[8*i +: 8]);
    repeat (v.gap) @(negedge clk);
    for (int i = 0; i < 4; i++) send_byte(v.wdata[8*i +: 8]);
    send_byte(v.cmd);
  endtask

  task automatic release_target();
    bus.devsel_ = 1'b1;
    bus.trdy_   = 1'b1;
    bus.stop_   = 1'b1;
    tgt_oe      = 1'b0;
  endtask

  task automatic run_target(input vec_t v);
    int  clks;
    bit  wr;
    wr = (v.cmd[3:0] == 4'h7);
    for (int i = 0; i < 20 && bus.frame_ !== 1'b0; i++) @(negedge clk);
    check("frame_asserted", {31'd0, bus.frame_}, 32'd0);
    check("addr_phase_ad", ad, v.addr);
    check("addr_phase_cbe", {28'd0, cbe_}, {28'd0, v.cmd[3:0]});
    @(negedge clk);
    clks = 0;
    while (bus.irdy_ === 1'b0 && clks < 40) begin
      clks++;
      if (clks == 1) begin
        check("data_phase_ad", ad, wr ? v.wdata : 32'hFFFF_FFFF);
        check("data_phase_cbe", {28'd0, cbe_}, 32'd0);
        check("data_phase_frame", {31'd0, bus.frame_}, 32'd1);
      end
      case (v.mode)
        M_OK, M_BOTH: if (clks >= v.at) begin
          bus.devsel_ = 1'b0;
          bus.trdy_   = 1'b0;
          if (v.mode == M_BOTH) bus.stop_ = 1'b0;
          if (!wr) begin tgt_val = v.rdata; tgt_oe = 1'b1; end
        end
        M_STOP: if (clks >= v.at) begin
          bus.devsel_ = 1'b0;
          bus.stop_   = 1'b0;
        end
        M_NOTRDY: bus.devsel_ = 1'b0;
        default: ;
      endcase
      @(negedge clk);
    end
    check("data_clocks", clks, v.exp_clks);
    release_target();
    #1;
    check("turn_ad_released", ad, 32'hFFFF_FFFF);
    check("turn_cbe_released", {28'd0, cbe_}, 32'h0000_000F);
    check("turn_frame_irdy", {30'd0, bus.frame_, bus.irdy_}, 32'd3);
  endtask

  task automatic run_vec(input vec_t v);
    bit bus_cmd;
    bit saw_frame;
    bus_cmd = (v.cmd[3:0] == 4'h6) || (v.cmd[3:0] == 4'h7);
    sb.push_back(v.exp_status);
    if (v.cmd[3:0] == 4'h6 && v.exp_status == 8'h00)
      for (int i = 0; i < 4; i++) sb.push_back(v.rdata[8*i +: 8]);
    send_frame(v);
    check("busy_on_accept", {31'd0, bus.busy}, 32'd1);
    if (bus_cmd) run_target(v);
    saw_frame = 1'b0;
    for (int i = 0; i < 200 && (sb.size() != 0 || bus.busy); i++) begin
      if (bus.frame_ === 1'b0) saw_frame = 1'b1;
      @(negedge clk);
    end
    check("responses_drained", sb.size(), 32'd0);
    check("busy_released", {31'd0, bus.busy}, 32'd0);
    if (!bus_cmd) check("no_bus_cycle", {31'd0, saw_frame}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_frame_irdy"}, {30'd0, bus.frame_, bus.irdy_}, 32'd3);
    check({tag, "_ad"}, ad, 32'hFFFF_FFFF);
    check({tag, "_cbe"}, {28'd0, cbe_}, 32'h0000_000F);
    check({tag, "_tx_load_busy"}, {30'd0, bus.tx_load, bus.busy}, 32'd0);
    check({tag, "_tx_data"}, {24'd0, bus.tx_data}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{32'h8000_0010, 32'hDEAD_BEEF, 8'h07, M_OK,     2, 32'h0,          2, 8'h00, 0};
    vecs[1] = '{32'h8000_0020, 32'hCAFE_F00D, 8'h06, M_OK,     1, 32'h1234_5678,  1, 8'h00, 0};
    vecs[2] = '{32'h8000_0030, 32'h0BAD_C0DE, 8'h06, M_NODEV,  0, 32'h0,          5, 8'h01, 0};
    vecs[3] = '{32'h0000_0000, 32'h1111_1111, 8'h03, M_NONE,   0, 32'h0,          0, 8'h02, 0};
    vecs[4] = '{32'h8000_0040, 32'h5555_AAAA, 8'h07, M_STOP,   2, 32'h0,          2, 8'h03, 0};
    vecs[5] = '{32'h8000_0050, 32'h1357_9BDF, 8'h06, M_NOTRDY, 0, 32'h0,         16, 8'h04, 0};
    vecs[6] = '{32'h8000_0060, 32'h2468_ACE0, 8'h06, M_BOTH,   3, 32'hA1B2_C3D4,  3, 8'h00, 0};
    vecs[7] = '{32'h8000_0070, 32'h0F0F_0F0F, 8'hA7, M_OK,     1, 32'h0,          1, 8'h00, 0};
    vecs[8] = '{32'h8000_0080, 32'h7654_3210, 8'h06, M_OK,     3, 32'h89AB_CDEF,  3, 8'h00, BYTE_TO - 10};
    vecs[9] = '{32'h0000_0004, 32'h0000_0000, 8'h00, M_NONE,   0, 32'h0,          0, 8'h02, 0};

    rst_         = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    tgt_val      = 32'h0;
    release_target();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_ = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // Reset pulsed in the middle of a DATA phase that the target never claims.
    send_frame(vecs[2]);
    for (int i = 0; i < 20 && bus.frame_ !== 1'b0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    check("mid_data_irdy", {31'd0, bus.irdy_}, 32'd0);
    rst_ = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    repeat (2) @(negedge clk);
    rst_ = 1'b1;
    repeat (30) @(negedge clk);
    check("post_reset_idle", {30'd0, bus.frame_, bus.irdy_}, 32'd3);
    run_vec(vecs[1]);

    // A stalled four-byte fragment must not merge with the next frame.
    for (int i = 0; i < 4; i++) send_byte(8'hA6 + 8'(i));
    repeat (BYTE_TO + 5) @(negedge clk);
    run_vec(vecs[0]);
    repeat (20) @(negedge clk);
    check("single_transaction", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_pci_master.md
UART_PCI_MASTER -- requirements
Module: uart_pci_master

Interface
REQ-001 SHALL have parameter DEVSEL_TIMEOUT, default 5, meaning clocks after the address phase to wait for devsel_ before a master abort.
REQ-002 SHALL have parameter TRDY_TIMEOUT, default 16, meaning clocks after devsel_ to wait for trdy_ before a timeout abort.
REQ-003 SHALL have parameter BYTE_TIMEOUT, default 65535, meaning idle clocks between command bytes before a partial frame is discarded.
REQ-004 clk  in  1  PCI/system clock; all logic on the rising edge.
REQ-005 rst_  in  1  reset, asynchronous, active-low.
REQ-006 rx_valid  in  1  one-clock pulse: rx_data holds a received UART byte.
REQ-007 rx_data  in  8  received byte.
REQ-008 tx_data  out  8  byte to the UART transmitter.
REQ-009 tx_load  out  1  one-clock pulse: transmitter accepts tx_data.
REQ-010 tx_busy  in  1  transmitter busy; high means no load allowed.
REQ-011 ad  inout  32  PCI multiplexed address/data.
REQ-012 cbe_  out  4  PCI command / byte enables, active-low.
REQ-013 frame_, irdy_  out  1 each  PCI master controls, active-low.
REQ-014 devsel_, trdy_, stop_  in  1 each  PCI target responses, active-low.
REQ-015 busy  out  1  high from command acceptance until the last response byte is loaded.

Function
REQ-016 Command frame SHALL be 9 bytes: bytes 0-3 address LSB first, bytes 4-7 write data LSB first, byte 8 command in bits [3:0]; bits [7:4] are ignored.
REQ-017 rx_valid SHALL be ignored in every state except COLLECT.
REQ-018 If byte count is nonzero and no rx_valid arrives within BYTE_TIMEOUT clocks, the count SHALL return to 0 and the partial frame SHALL be discarded, with no response.
REQ-019 FSM states SHALL be COLLECT, ADDR, DATA, TURN, RESP.
REQ-020 COLLECT: on byte 8, command 0x6 (mem read) or 0x7 (mem write) SHALL go to ADDR; any other command SHALL go to RESP with status 0x02 and no bus cycle.
REQ-021 ADDR (exactly 1 clock): frame_=0, irdy_=1, ad=address, cbe_=command.
REQ-022 DATA: frame_=1 (single data phase), irdy_=0, cbe_=4'h0, ad=write data for 0x7 or high-Z for 0x6.
REQ-023 In DATA, trdy_=0 and devsel_=0 sampled together SHALL complete the transfer with status 0x00; a read SHALL capture ad on that edge.
REQ-024 In DATA, devsel_ still 1 after DEVSEL_TIMEOUT clocks SHALL give status 0x01 (master abort).
REQ-025 In DATA, stop_=0 with trdy_=1 SHALL give status 0x03 (target stop/retry); no retry is attempted.
REQ-026 In DATA, devsel_=0 but trdy_ still 1 after TRDY_TIMEOUT clocks SHALL give status 0x04.
REQ-027 Every DATA exit SHALL go to TURN (1 clock): irdy_=1, frame_=1, ad high-Z, cbe_ high-Z; then to RESP.
REQ-028 ad and cbe_ SHALL be driven only in ADDR and DATA (writes drive ad in DATA; reads do not), and high-Z otherwise.
REQ-029 RESP SHALL send the status byte; a successful read SHALL follow it with 4 data bytes, LSB first. Failed reads and all writes send the status byte only.
REQ-030 tx_load SHALL pulse only when tx_busy=0. After each pulse, the block SHALL wait one clock, then wait for tx_busy=0 before the next byte.
REQ-031 After the last byte is loaded, the FSM SHALL return to COLLECT with byte count 0 and busy=0.
REQ-032 Timeout counters SHALL saturate at their limit, never wrap, and clear on entry to DATA.
REQ-033 If a stop_ condition and a completion are sampled on the same edge, completion SHALL take priority.

Reset
REQ-034 While rst_=0, independent of clk, the FSM SHALL be in COLLECT with byte count 0, and the outputs SHALL be: frame_=1, irdy_=1, ad and cbe_ high-Z, tx_load=0, tx_data=0, busy=0, all counters 0.
REQ-035 Reset asserted mid-transaction SHALL abandon the transaction immediately with no response, and release the bus on the same assertion.

Verification
REQ-036 Write: bytes 10 00 00 80, EF BE AD DE, 07; target asserts devsel_ and trdy_ in the 2nd DATA clock -> ADDR drives ad=0x80000010 with cbe_=7, DATA drives ad=0xDEADBEEF with cbe_=0, one response byte 0x00.
REQ-037 Read: address 0x80000020, command 06; target returns 0x12345678 -> ad high-Z in DATA, response bytes 00 78 56 34 12.
REQ-038 No devsel_ -> irdy_ deasserts after exactly DEVSEL_TIMEOUT=5 DATA clocks, response 0x01.
REQ-039 Command byte 0x03 -> no frame_ assertion, response 0x02; stop_=0 in DATA with trdy_=1 -> response 0x03.
REQ-040 4 bytes, then silence for BYTE_TIMEOUT clocks, then a full valid frame -> first fragment discarded, exactly one transaction.
REQ-041 rst_ pulsed low during DATA -> frame_=1 and irdy_=1 immediately, ad high-Z, no tx_load; next frame executes normally.
